// File: rtl/matmul_pkg.sv
// ---------------------------------------------------------------------------
// matmul_pkg
// Shared definitions for the matmul microcode sequencer:
//   - state_e            : sequencer FSM states (fixed encodings IDLE..EXIT)
//   - OPC_MATMUL/F3_*    : opcode/funct3 of STARTMATMUL2 and ENDMATMUL
//   - UCODE_BASE_DEFAULT : default first fetch address in microcode memory
//   - CNT_W              : width of the RUN-cycle counter
// ---------------------------------------------------------------------------
package matmul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENTER = 2'd1,
    ST_RUN   = 2'd2,
    ST_EXIT  = 2'd3
  } state_e;

  localparam logic [6:0]  OPC_MATMUL         = 7'b1111010;
  localparam logic [2:0]  F3_START           = 3'b000;
  localparam logic [2:0]  F3_END             = 3'b111;
  localparam logic [31:0] UCODE_BASE_DEFAULT = 32'h0000_0000;
  localparam int          CNT_W              = 16;

  // Decode helpers for the stage that produces start_req / end_req.
  function automatic logic is_start_insn(input logic [6:0] opcode, input logic [2:0] funct3);
    return (opcode == OPC_MATMUL) && (funct3 == F3_START);
  endfunction

  function automatic logic is_end_insn(input logic [6:0] opcode, input logic [2:0] funct3);
    return (opcode == OPC_MATMUL) && (funct3 == F3_END);
  endfunction

endpackage

// File: rtl/matmul_sat_cnt.sv
// ---------------------------------------------------------------------------
// matmul_sat_cnt
// 16-bit saturating up-counter with synchronous clear and count enable.
// Clear has priority over enable; the count sticks at all-ones.
// Ports:
//   clk   in  clock
//   reset in  synchronous active-low reset (count -> 0)
//   clr   in  synchronous clear
//   en    in  count enable
//   count out current count
// ---------------------------------------------------------------------------
module matmul_sat_cnt
  import matmul_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/matmul_seq_ctrl.sv
// ---------------------------------------------------------------------------
// matmul_seq_ctrl
// Sequencer that diverts instruction fetch into microcode memory on
// STARTMATMUL2 and returns to the saved PC on ENDMATMUL.
//   IDLE  -> ENTER : accepted start; return PC (pc_d+4) captured, save_pc pulses
//   ENTER -> RUN   : fetch forced to UCODE_BASE, F/D flushed, microcode selected
//   RUN   -> EXIT  : accepted end (or watchdog timeout)
//   EXIT  -> IDLE  : fetch forced to the saved PC, F/D flushed
// Optional feature: define MATMUL_WDOG_EN to bound RUN to WDOG_LIMIT cycles.
// Ports:
//   clk, reset (sync, active-low)
//   start_req, end_req, stall_d, pc_d        : decode-stage inputs
//   im_sel, save_pc, pc_override,
//   pc_override_val, flush_fd                : fetch control (combinational)
//   pc_backup, state, ucode_cycles,
//   proto_err, wdog_to                       : registered status
// ---------------------------------------------------------------------------
module matmul_seq_ctrl
  import matmul_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] UCODE_BASE = XLEN'(UCODE_BASE_DEFAULT),
  parameter int              WDOG_LIMIT = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_req,
  input  logic             end_req,
  input  logic             stall_d,
  input  logic [XLEN-1:0]  pc_d,
  output logic             im_sel,
  output logic             save_pc,
  output logic             pc_override,
  output logic [XLEN-1:0]  pc_override_val,
  output logic             flush_fd,
  output logic [XLEN-1:0]  pc_backup,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] ucode_cycles,
  output logic             proto_err,
  output logic             wdog_to
);

  if ((WDOG_LIMIT < 1) || (WDOG_LIMIT > 65536)) begin : g_bad_wdog_limit
    $error("WDOG_LIMIT must lie in 1..65536");
  end

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_backup_q, pc_backup_d;
  logic            proto_err_q, proto_err_d;
  logic            start_acc, end_acc;
  logic            cnt_clr, cnt_en;
  logic            wdog_hit;
  logic [CNT_W-1:0] cnt;

  // A request only counts when decode is not stalled.
  assign start_acc = start_req & ~stall_d;
  assign end_acc   = end_req & ~stall_d;

  always_comb begin
    state_d         = state_q;
    pc_backup_d     = pc_backup_q;
    proto_err_d     = proto_err_q;
    cnt_clr         = 1'b0;
    cnt_en          = 1'b0;
    im_sel          = 1'b0;
    save_pc         = 1'b0;
    pc_override     = 1'b0;
    pc_override_val = '0;
    flush_fd        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Start wins over a simultaneous end; a stray end is still an error.
        if (start_acc) begin
          save_pc     = 1'b1;
          pc_backup_d = pc_d + XLEN'(4);
          cnt_clr     = 1'b1;
          state_d     = ST_ENTER;
        end
        if (end_acc) proto_err_d = 1'b1;
      end
      ST_ENTER: begin
        im_sel          = 1'b1;
        pc_override     = 1'b1;
        pc_override_val = UCODE_BASE;
        flush_fd        = 1'b1;
        state_d         = ST_RUN;
      end
      ST_RUN: begin
        im_sel = 1'b1;
        cnt_en = 1'b1;
        if (start_acc) proto_err_d = 1'b1;
        if (end_acc || wdog_hit) state_d = ST_EXIT;
      end
      ST_EXIT: begin
        // Requests seen here belong to the instruction being flushed.
        pc_override     = 1'b1;
        pc_override_val = pc_backup_q;
        flush_fd        = 1'b1;
        state_d         = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Fetch controls are quiet while reset is held, whatever the state.
    if (!reset) begin
      im_sel          = 1'b0;
      save_pc         = 1'b0;
      pc_override     = 1'b0;
      pc_override_val = '0;
      flush_fd        = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      pc_backup_q <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_backup_q <= pc_backup_d;
      proto_err_q <= proto_err_d;
    end
  end

  matmul_sat_cnt u_cycle_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (cnt)
  );

`ifdef MATMUL_WDOG_EN
  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(WDOG_LIMIT - 1);
  logic wdog_to_q, wdog_to_d;

  // The count seen here is the value before this RUN cycle is added.
  assign wdog_hit = (state_q == ST_RUN) && (cnt == WDOG_LAST);

  always_comb begin
    wdog_to_d = wdog_to_q | wdog_hit;
  end

  always_ff @(posedge clk) begin
    if (!reset) wdog_to_q <= 1'b0;
    else        wdog_to_q <= wdog_to_d;
  end

  assign wdog_to = wdog_to_q;
`else
  assign wdog_hit = 1'b0;
  assign wdog_to  = 1'b0;
`endif

  assign pc_backup    = pc_backup_q;
  assign state        = state_q;
  assign ucode_cycles = cnt;
  assign proto_err    = proto_err_q;

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_matmul_seq_ctrl
// Scoreboard bench: the driver applies one set of inputs per cycle, predicts
// that cycle's outputs from a behavioural model and queues the prediction;
// a monitor on the falling edge pops and compares against the DUT.
// Honours MATMUL_WDOG_EN (watchdog limit 8 when defined).
// ---------------------------------------------------------------------------
module tb_matmul_seq_ctrl;

  localparam int XLEN = 32;
`ifdef MATMUL_WDOG_EN
  localparam int WDOG    = 8;
  localparam bit WDOG_ON = 1'b1;
`else
  localparam int WDOG    = 256;
  localparam bit WDOG_ON = 1'b0;
`endif
  localparam logic [31:0] UBASE = 32'h0000_0000;

  logic            clk = 1'b0;
  logic            reset;
  logic            start_req, end_req, stall_d;
  logic [XLEN-1:0] pc_d;
  logic            im_sel, save_pc, pc_override, flush_fd, proto_err, wdog_to;
  logic [XLEN-1:0] pc_override_val, pc_backup;
  logic [1:0]      state;
  logic [15:0]     ucode_cycles;

  matmul_seq_ctrl #(.XLEN(XLEN), .WDOG_LIMIT(WDOG)) dut (
    .clk             (clk),
    .reset           (reset),
    .start_req       (start_req),
    .end_req         (end_req),
    .stall_d         (stall_d),
    .pc_d            (pc_d),
    .im_sel          (im_sel),
    .save_pc         (save_pc),
    .pc_override     (pc_override),
    .pc_override_val (pc_override_val),
    .flush_fd        (flush_fd),
    .pc_backup       (pc_backup),
    .state           (state),
    .ucode_cycles    (ucode_cycles),
    .proto_err       (proto_err),
    .wdog_to         (wdog_to)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic        im_sel, save_pc, pc_override, flush_fd, proto_err, wdog_to;
    logic [31:0] ov_val, backup;
    logic [1:0]  state;
    logic [15:0] cycles;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc_no   = 0;

  // Behavioural model: mode is the episode phase (0 idle, 1 enter, 2 run, 3 exit).
  int          m_mode   = 0;
  logic [31:0] m_backup = '0;
  int          m_cycles = 0;
  bit          m_perr   = 1'b0;
  bit          m_wto    = 1'b0;

  task automatic check(input string name, input int cyc, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=0x%0h expected=0x%0h", name, cyc, act, want);
    end
  endtask

  // One clock cycle of stimulus plus its prediction.
  task automatic cyc(input bit rst_n, input bit st, input bit en, input bit stl, input logic [31:0] pc);
    exp_t e;
    bit   st_ok, en_ok, timeout;
    @(posedge clk);
    #1;
    reset     = rst_n;
    start_req = st;
    end_req   = en;
    stall_d   = stl;
    pc_d      = pc;
    st_ok     = st && !stl;
    en_ok     = en && !stl;

    e = '{cyc: cyc_no, im_sel: 1'b0, save_pc: 1'b0, pc_override: 1'b0, flush_fd: 1'b0,
          proto_err: m_perr, wdog_to: m_wto, ov_val: 32'h0, backup: m_backup,
          state: 2'(m_mode), cycles: 16'(m_cycles)};
    if (rst_n) begin
      case (m_mode)
        0: e.save_pc = st_ok;
        1: begin e.im_sel = 1'b1; e.pc_override = 1'b1; e.ov_val = UBASE; e.flush_fd = 1'b1; end
        2: e.im_sel = 1'b1;
        default: begin e.pc_override = 1'b1; e.ov_val = m_backup; e.flush_fd = 1'b1; end
      endcase
    end
    exp_q.push_back(e);
    cyc_no++;

    if (!rst_n) begin
      m_mode = 0; m_backup = '0; m_cycles = 0; m_perr = 1'b0; m_wto = 1'b0;
    end else begin
      case (m_mode)
        0: begin
          if (en_ok) m_perr = 1'b1;
          if (st_ok) begin
            m_backup = pc + 32'd4;
            m_cycles = 0;
            m_mode   = 1;
          end
        end
        1: m_mode = 2;
        2: begin
          timeout  = WDOG_ON && (m_cycles == WDOG - 1);
          m_cycles = (m_cycles >= 65535) ? 65535 : m_cycles + 1;
          if (st_ok) m_perr = 1'b1;
          if (timeout) m_wto = 1'b1;
          if (en_ok || timeout) m_mode = 3;
        end
        default: m_mode = 0;
      endcase
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  // Monitor: compare the DUT against the oldest prediction each falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("im_sel",          e.cyc, 32'(im_sel),       32'(e.im_sel));
      check("save_pc",         e.cyc, 32'(save_pc),      32'(e.save_pc));
      check("pc_override",     e.cyc, 32'(pc_override),  32'(e.pc_override));
      check("pc_override_val", e.cyc, pc_override_val,   e.ov_val);
      check("flush_fd",        e.cyc, 32'(flush_fd),     32'(e.flush_fd));
      check("pc_backup",       e.cyc, pc_backup,         e.backup);
      check("state",           e.cyc, 32'(state),        32'(e.state));
      check("ucode_cycles",    e.cyc, 32'(ucode_cycles), 32'(e.cycles));
      check("proto_err",       e.cyc, 32'(proto_err),    32'(e.proto_err));
      check("wdog_to",         e.cyc, 32'(wdog_to),      32'(e.wdog_to));
    end
  end

  initial begin
    reset = 1'b0; start_req = 1'b0; end_req = 1'b0; stall_d = 1'b0; pc_d = '0;

    // Reset with requests present: outputs must stay quiet.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h40);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    idle(2);

    // Basic episode: start at 0x20, end after 10 RUN cycles.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h20);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);          // ENTER: requests ignored
    idle(9);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);          // EXIT (or later) requests
    idle(3);

    // Stalled start for 3 cycles, then accepted.
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b1, 32'h100);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h100);
    idle(3);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 32'h0);          // stalled end: no effect
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 32'h0);          // stalled nested start: no error
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);          // nested start: proto_err
    idle(2);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    idle(3);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);          // end in IDLE: proto_err stays
    idle(3);

    // Clear errors, then both requests together in IDLE and in RUN.
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h200);
    idle(3);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    idle(3);

    // Reset during RUN cycle 5: straight to IDLE, no EXIT pulse.
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h300);
    idle(5);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    idle(3);

    // Return PC wraps modulo 2^32.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC);
    idle(3);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    idle(3);

    // Long run without end: watchdog exit when compiled in, else stays in RUN.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h400);
    idle(310);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    idle(3);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 99) != 0),
          ($urandom_range(0, 5) == 0),
          ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 3) == 0),
          {$urandom_range(0, 32'h3FFF_FFFF), 2'b00});
    end
    idle(2);

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d pending expected=0 pending", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
